ro_cache_cfg_sequencer: RTL



---
 rtl/mempool_pkg.sv | 37 +++
 rtl/ro_cache_flush_collector.sv | 36 +++
 rtl/ro_cache_cfg_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mempool_pkg.sv
// +----------------------------------------------------------------------------+
// | mempool_pkg                                                                |
// | Shared types for the read-only cache control path of the interconnect.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package mempool_pkg;

    localparam int unsigned ROCacheNumAddrRules = 4;
    localparam int unsigned ROCacheAddrWidth    = 32;

    typedef logic [ROCacheAddrWidth-1:0] ro_cache_addr_t;

    typedef struct packed {
        logic                                      enable;
        logic                                      flush_valid;
        ro_cache_addr_t [ROCacheNumAddrRules-1:0]  start_addr;
        ro_cache_addr_t [ROCacheNumAddrRules-1:0]  end_addr;
    } ro_cache_ctrl_t;

    // Opcode 2'd3 is reserved and intentionally has no literal.
    typedef enum logic [1:0] {
        CMD_SET_EN    = 2'd0,
        CMD_SET_RANGE = 2'd1,
        CMD_FLUSH     = 2'd2
    } ro_cache_cmd_e;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_SETTLE    = 3'd1;
    localparam logic [2:0] c_ST_FLUSH_REQ = 3'd2;
    localparam logic [2:0] c_ST_UPDATE    = 3'd3;
    localparam logic [2:0] c_ST_RESTORE   = 3'd4;

endpackage

`default_nettype wire

// File: rtl/ro_cache_flush_collector.sv
// +----------------------------------------------------------------------------+
// | ro_cache_flush_collector                                                   |
// | Sticky per-cache flush acknowledge mask with clear and all-acked flag.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ro_cache_flush_collector #(
    parameter int unsigned NumCaches = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_sample,
    input  logic                 i_clear,
    input  logic [NumCaches-1:0] i_ready,
    output logic                 o_all_acked
);

    logic [NumCaches-1:0] r_mask;
    logic [NumCaches-1:0] w_seen;

    // Current-cycle acks count so a cache acking late still completes now.
    assign w_seen      = r_mask | i_ready;
    assign o_all_acked = &w_seen;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_mask <= '0;
        end else if (i_sample) begin
            r_mask <= w_seen;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ro_cache_cfg_sequencer.sv
// +----------------------------------------------------------------------------+
// | ro_cache_cfg_sequencer                                                     |
// | Sequences enable/range/flush commands and broadcasts the RO cache control. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module ro_cache_cfg_sequencer
    import mempool_pkg::*;
#(
    parameter int unsigned NumCaches    = 4,
    parameter int unsigned AddrWidth    = 32,
    parameter int unsigned NrAddrRules  = ROCacheNumAddrRules,
    parameter int unsigned SettleCycles = 4,
    parameter int unsigned CntWidth     = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             cmd_valid_i,
    output logic                             cmd_ready_o,
    input  logic [1:0]                       cmd_op_i,
    input  logic                             cmd_enable_i,
    input  logic [NrAddrRules*AddrWidth-1:0] cmd_start_addr_i,
    input  logic [NrAddrRules*AddrWidth-1:0] cmd_end_addr_i,
    input  logic [NumCaches-1:0]             flush_ready_i,
    output ro_cache_ctrl_t                   ro_cache_ctrl_o,
    output logic                             busy_o,
    output logic [CntWidth-1:0]              flush_count_o,
    output logic                             cmd_err_o
);

    localparam int unsigned c_SCW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
    localparam logic [c_SCW-1:0] c_SETTLE_INIT = c_SCW'(SettleCycles - 1);

    logic [2:0]                       r_state;
    logic [c_SCW-1:0]                 r_settle_cnt;
    logic                             r_enable;
    logic                             r_en_saved;
    logic                             r_is_range;
    logic [NrAddrRules*AddrWidth-1:0] r_start_addr;
    logic [NrAddrRules*AddrWidth-1:0] r_end_addr;
    logic [NrAddrRules*AddrWidth-1:0] r_pend_start;
    logic [NrAddrRules*AddrWidth-1:0] r_pend_end;
    logic [CntWidth-1:0]              r_flush_count;
    logic                             r_cmd_err;

    logic w_accept;
    logic w_in_flush;
    logic w_all_acked;

    assign cmd_ready_o = (r_state == c_ST_IDLE);
    assign w_accept    = cmd_valid_i && cmd_ready_o;
    assign w_in_flush  = (r_state == c_ST_FLUSH_REQ);

    ro_cache_flush_collector #(
        .NumCaches (NumCaches)
    ) u_flush_collector (
        .clk         (clk_i),
        .rst         (rst_i),
        .i_sample    (w_in_flush),
        .i_clear     (w_in_flush && w_all_acked),
        .i_ready     (flush_ready_i),
        .o_all_acked (w_all_acked)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_IDLE;
            r_settle_cnt  <= '0;
            r_enable      <= 1'b0;
            r_en_saved    <= 1'b0;
            r_is_range    <= 1'b0;
            r_start_addr  <= '0;
            r_end_addr    <= '0;
            r_pend_start  <= '0;
            r_pend_end    <= '0;
            r_flush_count <= '0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_cmd_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        if (cmd_op_i == CMD_SET_EN) begin
                            r_enable <= cmd_enable_i;
                        end else if (cmd_op_i == CMD_SET_RANGE || cmd_op_i == CMD_FLUSH) begin
                            r_en_saved   <= r_enable;
                            r_enable     <= 1'b0;
                            r_is_range   <= (cmd_op_i == CMD_SET_RANGE);
                            r_pend_start <= cmd_start_addr_i;
                            r_pend_end   <= cmd_end_addr_i;
                            r_settle_cnt <= c_SETTLE_INIT;
                            r_state      <= c_ST_SETTLE;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt == '0) begin
                        r_state <= c_ST_FLUSH_REQ;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 1'b1;
                    end
                end
                c_ST_FLUSH_REQ: begin
                    if (w_all_acked) begin
                        r_state <= c_ST_UPDATE;
                    end
                end
                c_ST_UPDATE: begin
                    // Caches are disabled and flushed here, so the range swap is safe.
                    if (r_is_range) begin
                        r_start_addr <= r_pend_start;
                        r_end_addr   <= r_pend_end;
                    end
                    if (r_flush_count != {CntWidth{1'b1}}) begin
                        r_flush_count <= r_flush_count + 1'b1;
                    end
                    r_state <= c_ST_RESTORE;
                end
                c_ST_RESTORE: begin
                    r_enable <= r_en_saved;
                    r_state  <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign ro_cache_ctrl_o.enable      = r_enable;
    assign ro_cache_ctrl_o.flush_valid = w_in_flush;
    assign ro_cache_ctrl_o.start_addr  = r_start_addr;
    assign ro_cache_ctrl_o.end_addr    = r_end_addr;
    assign busy_o                      = (r_state != c_ST_IDLE);
    assign flush_count_o               = r_flush_count;
    assign cmd_err_o                   = r_cmd_err;

endmodule

`default_nettype wire
